// File: rtl/pc_fetch_pkg.sv
// Shared global parameters for the fetch slice: opcode width, NOP encoding and
// the sequencer state type.
`include "opcodes.sv"

package pc_fetch_pkg;

   localparam int unsigned OPCODE_SIZE = `OPCODE_SIZE;
   localparam logic [OPCODE_SIZE-1:0] NOP_OPCODE = `NOP;

   typedef enum logic {
      StRun  = 1'b0,
      StHalt = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/opcodes.sv
// Opcode field width and the opcode encodings that the decode stage shares.
`ifndef OPCODES_SV
`define OPCODES_SV

`define OPCODE_SIZE 6

`define NOP 6'h3f
`define ADD 6'h01
`define SUB 6'h02
`define LDI 6'h03
`define JMP 6'h04

`endif

// File: rtl/pc_fetch_switch_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for the
// handshake switch.
module switch_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic [CntW-1:0] cnt_q;
   logic            level_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         // Any agreement with the accepted level restarts the stability count.
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntLast) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign level = level_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter sequencer: presents the ROM word for the current PC, advances
// on decoder request, and either wraps or halts after the last program word.
`include "opcodes.sv"

module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter int unsigned          PC_WIDTH        = 8,
   parameter int unsigned          INSN_WIDTH      = 24,
   parameter int unsigned          OPCODE_SIZE     = `OPCODE_SIZE,
   parameter int unsigned          DEBOUNCE_CYCLES = 16,
   parameter logic [PC_WIDTH-1:0]  LAST_ADDR       = {PC_WIDTH{1'b1}},
   parameter bit                   WRAP            = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   switch_raw,
   input  logic                   pc_inc,
   input  logic [INSN_WIDTH-1:0]  prog_data,
   output logic [PC_WIDTH-1:0]    prog_addr,
   output logic [INSN_WIDTH-1:0]  instr,
   output logic [OPCODE_SIZE-1:0] opcode,
   output logic                   handshake_switch,
   output logic                   halted
);

   // Word fed to decode while halted: NOP opcode, everything else cleared.
   localparam logic [INSN_WIDTH-1:0] HaltWord =
      {OPCODE_SIZE'(`NOP), {(INSN_WIDTH - OPCODE_SIZE){1'b0}}};

   logic [PC_WIDTH-1:0] pc_q;
   fetch_state_t        state_q;
   logic                halted_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         state_q  <= StRun;
         halted_q <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (pc_inc) begin
                  if (pc_q != LAST_ADDR) begin
                     pc_q <= pc_q + PC_WIDTH'(1);
                  end else if (WRAP) begin
                     pc_q <= '0;
                  end else begin
                     state_q  <= StHalt;
                     halted_q <= 1'b1;
                  end
               end
            end
            StHalt: begin
               state_q  <= StHalt;
               halted_q <= 1'b1;
            end
            default: begin
               state_q  <= StHalt;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   assign prog_addr = pc_q;
   assign halted    = halted_q;
   assign instr     = halted_q ? HaltWord : prog_data;
   assign opcode    = instr[INSN_WIDTH-1 -: OPCODE_SIZE];

   switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_switch_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (switch_raw),
      .level(handshake_switch)
   );

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: three 3-bit-PC instances (halt at 7, wrap at 7,
// halt at 5) share one stimulus stream; a negedge monitor checks queued expectations.
module tb_pc_fetch;
   import pc_fetch_pkg::*;

   localparam int unsigned PW = 3;
   localparam int unsigned IW = 24;
   localparam int unsigned OW = 6;

   localparam int SigAddrA  = 0;
   localparam int SigAddrB  = 1;
   localparam int SigAddrC  = 2;
   localparam int SigHaltA  = 3;
   localparam int SigHaltB  = 4;
   localparam int SigHaltC  = 5;
   localparam int SigHsA    = 6;
   localparam int SigHsC    = 7;
   localparam int SigOpA    = 8;
   localparam int SigInstrA = 9;

   typedef struct {
      int          cyc;
      int          sig;
      logic [23:0] val;
      string       name;
   } sb_item_t;

   logic clk = 1'b0;
   logic reset;
   logic switch_raw;
   logic pc_inc;

   logic [PW-1:0] addr_a, addr_b, addr_c;
   logic [IW-1:0] data_a, data_b, data_c;
   logic [IW-1:0] instr_a, instr_b, instr_c;
   logic [OW-1:0] op_a, op_b, op_c;
   logic          hs_a, hs_b, hs_c;
   logic          halt_a, halt_b, halt_c;

   int       cyc = 0;
   int       tests = 0;
   int       fails = 0;
   sb_item_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] rom(input logic [2:0] a);
      logic [17:0] low;
      low = 18'h2bcde ^ {15'b0, a};
      return {3'b101, a, low};
   endfunction

   assign data_a = rom(addr_a);
   assign data_b = rom(addr_b);
   assign data_c = rom(addr_c);

   pc_fetch #(
      .PC_WIDTH(PW), .INSN_WIDTH(IW), .OPCODE_SIZE(OW), .DEBOUNCE_CYCLES(4),
      .LAST_ADDR(3'd7), .WRAP(1'b0)
   ) dut_a (
      .clk(clk), .reset(reset), .switch_raw(switch_raw), .pc_inc(pc_inc),
      .prog_data(data_a), .prog_addr(addr_a), .instr(instr_a), .opcode(op_a),
      .handshake_switch(hs_a), .halted(halt_a)
   );

   pc_fetch #(
      .PC_WIDTH(PW), .INSN_WIDTH(IW), .OPCODE_SIZE(OW), .DEBOUNCE_CYCLES(4),
      .LAST_ADDR(3'd7), .WRAP(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .switch_raw(switch_raw), .pc_inc(pc_inc),
      .prog_data(data_b), .prog_addr(addr_b), .instr(instr_b), .opcode(op_b),
      .handshake_switch(hs_b), .halted(halt_b)
   );

   pc_fetch #(
      .PC_WIDTH(PW), .INSN_WIDTH(IW), .OPCODE_SIZE(OW), .DEBOUNCE_CYCLES(4),
      .LAST_ADDR(3'd5), .WRAP(1'b0)
   ) dut_c (
      .clk(clk), .reset(reset), .switch_raw(switch_raw), .pc_inc(pc_inc),
      .prog_data(data_c), .prog_addr(addr_c), .instr(instr_c), .opcode(op_c),
      .handshake_switch(hs_c), .halted(halt_c)
   );

   function automatic logic [23:0] actual(input int sig);
      case (sig)
         SigAddrA:  return {21'b0, addr_a};
         SigAddrB:  return {21'b0, addr_b};
         SigAddrC:  return {21'b0, addr_c};
         SigHaltA:  return {23'b0, halt_a};
         SigHaltB:  return {23'b0, halt_b};
         SigHaltC:  return {23'b0, halt_c};
         SigHsA:    return {23'b0, hs_a};
         SigHsC:    return {23'b0, hs_c};
         SigOpA:    return {18'b0, op_a};
         SigInstrA: return instr_a;
         default:   return 24'hxxxxxx;
      endcase
   endfunction

   // Monitor: compares every expectation stamped for the cycle just completed.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         sb_item_t it;
         logic [23:0] act;
         it  = sb.pop_front();
         act = actual(it.sig);
         tests++;
         if (it.cyc != cyc || act !== it.val) begin
            fails++;
            $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", it.name, it.cyc, act,
                     it.val);
         end
      end
   end

   task automatic expect_sig(input string name, input int sig, input logic [23:0] val);
      sb.push_back('{cyc: cyc, sig: sig, val: val, name: name});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_run_a(input string name, input logic [2:0] a);
      expect_sig({name, "_addr_a"}, SigAddrA, {21'b0, a});
      expect_sig({name, "_instr_a"}, SigInstrA, rom(a));
      expect_sig({name, "_halt_a"}, SigHaltA, 24'd0);
   endtask

   initial begin
      logic [23:0] halt_word;
      halt_word = {NOP_OPCODE, 18'b0};
      reset = 1'b1;
      pc_inc = 1'b1;
      switch_raw = 1'b1;

      // Reset state, with pc_inc and the switch both active.
      step();
      expect_run_a("rst", 3'd0);
      expect_sig("rst_addr_b", SigAddrB, 24'd0);
      expect_sig("rst_addr_c", SigAddrC, 24'd0);
      expect_sig("rst_halt_b", SigHaltB, 24'd0);
      expect_sig("rst_halt_c", SigHaltC, 24'd0);
      expect_sig("rst_hs", SigHsA, 24'd0);

      // Straight-line advance.
      reset = 1'b0;
      switch_raw = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         expect_run_a("adv", 3'(k));
         expect_sig("adv_addr_b", SigAddrB, 24'(k));
         expect_sig("adv_addr_c", SigAddrC, 24'(k));
         expect_sig("adv_hs", SigHsA, 24'd0);
      end

      // Stall at PC=3, then resume.
      reset = 1'b1;
      step();
      expect_sig("rst2_addr_a", SigAddrA, 24'd0);
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) step();
      expect_sig("pre_stall_addr_a", SigAddrA, 24'd3);
      pc_inc = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         expect_sig("stall_addr_a", SigAddrA, 24'd3);
         expect_sig("stall_addr_c", SigAddrC, 24'd3);
      end
      pc_inc = 1'b1;
      step();
      expect_run_a("resume", 3'd4);
      expect_sig("resume_addr_b", SigAddrB, 24'd4);

      // End of program: halt at 7 (a), wrap at 7 (b), halt at 5 (c).
      step();
      expect_run_a("end5", 3'd5);
      expect_sig("end5_addr_c", SigAddrC, 24'd5);
      expect_sig("end5_halt_c", SigHaltC, 24'd0);
      step();
      expect_run_a("end6", 3'd6);
      expect_sig("end6_addr_c", SigAddrC, 24'd5);
      expect_sig("end6_halt_c", SigHaltC, 24'd1);
      step();
      expect_run_a("end7", 3'd7);
      expect_sig("end7_addr_b", SigAddrB, 24'd7);
      step();
      expect_sig("halt_addr_a", SigAddrA, 24'd7);
      expect_sig("halt_halt_a", SigHaltA, 24'd1);
      expect_sig("halt_op_a", SigOpA, {18'b0, NOP_OPCODE});
      expect_sig("halt_instr_a", SigInstrA, halt_word);
      expect_sig("wrap_addr_b", SigAddrB, 24'd0);
      expect_sig("wrap_halt_b", SigHaltB, 24'd0);
      step();
      expect_sig("halt_hold_a", SigAddrA, 24'd7);
      expect_sig("wrap_next_b", SigAddrB, 24'd1);
      expect_sig("halt_hold_c", SigAddrC, 24'd5);

      // Debounce while halted: rise and fall each take 6 edges.
      switch_raw = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         expect_sig("db_rise", SigHsA, (k == 6) ? 24'd1 : 24'd0);
      end
      switch_raw = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         expect_sig("db_fall", SigHsA, (k == 6) ? 24'd0 : 24'd1);
         expect_sig("db_fall_addr_a", SigAddrA, 24'd7);
      end

      // A 3-cycle pulse is rejected.
      switch_raw = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         expect_sig("pulse_hs", SigHsA, 24'd0);
      end
      switch_raw = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         expect_sig("pulse_after_hs", SigHsA, 24'd0);
      end

      // Reset mid-debounce (counter at 2) with c halted at 5.
      switch_raw = 1'b1;
      for (int k = 0; k < 4; k++) step();
      expect_sig("mid_db_hs", SigHsC, 24'd0);
      expect_sig("mid_db_halt_c", SigHaltC, 24'd1);
      reset = 1'b1;
      step();
      expect_sig("rst3_addr_c", SigAddrC, 24'd0);
      expect_sig("rst3_halt_c", SigHaltC, 24'd0);
      expect_sig("rst3_addr_a", SigAddrA, 24'd0);
      expect_sig("rst3_hs", SigHsC, 24'd0);
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         expect_sig("restart_hs", SigHsC, (k == 6) ? 24'd1 : 24'd0);
         expect_run_a("restart", 3'(k));
         expect_sig("restart_addr_c", SigAddrC, (k >= 5) ? 24'd5 : 24'(k));
         expect_sig("restart_halt_c", SigHaltC, (k == 6) ? 24'd1 : 24'd0);
      end

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
